// File: rtl/axil_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register file responder:
// response codes, channel FSM state types, the out-of-range read filler
// and the byte-strobe merge helper.
package axil_regfile_pkg;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite responder exposing a word-addressed register file.
// Word 0 is a constant ID register; words 1..NUM_REGS-1 are read/write and
// are presented flattened on reg_q, with a one-cycle write pulse per word.
// Optional build macro AXIL_REGFILE_SLVERR_EN: when defined, out-of-range
// accesses answer SLVERR (reads return 0); otherwise they answer OKAY and
// reads return DEFAULT_RDATA. Out-of-range writes never change state.
module axil_regfile_slave
  import axil_regfile_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 11,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'h58475301
) (
  input  logic                    aclk,
  input  logic                    aclk_reset_n,
  input  logic [ADDR_WIDTH-1:0]   aclk_awaddr,
  input  logic [2:0]              aclk_awprot,
  input  logic                    aclk_awvalid,
  output logic                    aclk_awready,
  input  logic [DATA_WIDTH-1:0]   aclk_wdata,
  input  logic [DATA_WIDTH/8-1:0] aclk_wstrb,
  input  logic                    aclk_wvalid,
  output logic                    aclk_wready,
  output logic [1:0]              aclk_bresp,
  output logic                    aclk_bvalid,
  input  logic                    aclk_bready,
  input  logic [ADDR_WIDTH-1:0]   aclk_araddr,
  input  logic [2:0]              aclk_arprot,
  input  logic                    aclk_arvalid,
  output logic                    aclk_arready,
  output logic [DATA_WIDTH-1:0]   aclk_rdata,
  output logic [1:0]              aclk_rresp,
  output logic                    aclk_rvalid,
  input  logic                    aclk_rready,
  output logic [NUM_REGS*32-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0]  OOR_RESP  = RESP_SLVERR;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
`else
  localparam logic [1:0]  OOR_RESP  = RESP_OKAY;
  localparam logic [31:0] OOR_RDATA = DEFAULT_RDATA;
`endif

  // ------------------------------------------------------------------
  // Write channel state
  // ------------------------------------------------------------------
  wr_state_t               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    wr_commit;
  logic                    wr_in_range;

  // ------------------------------------------------------------------
  // Read channel state
  // ------------------------------------------------------------------
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [IDX_W-1:0]      rd_idx;
  logic [31:0]           rd_word;
  logic [1:0]            rd_resp;

  // Register storage, flattened, plus per-word write pulses
  logic [NUM_REGS*32-1:0] regs_flat;
  logic [NUM_REGS-1:0]    pulse_q, pulse_d;

  // Protection bits and the byte offset within a word carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{aclk_awprot, aclk_arprot, aclk_awaddr[1:0], aclk_araddr[1:0]};

  assign wr_in_range = (32'(wr_idx_q) < NUM_REGS);

  // Write FSM: latch AW and W independently, commit once both are held,
  // then hold the B response until the master takes it.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_idx_d   = wr_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          // Both halves present: the register update happens on this edge.
          wr_commit  = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_in_range ? RESP_OKAY : OOR_RESP;
          wr_state_d = W_RESP;
        end else begin
          if (aclk_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            wr_idx_d  = aclk_awaddr[ADDR_WIDTH-1:2];
          end
          if (aclk_wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = aclk_wdata;
            wstrb_d  = aclk_wstrb;
          end
        end
      end
      W_RESP: begin
        if (aclk_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
      end
    endcase
    // Ready flags are registered so they read 0 while reset is applied.
    awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
  end

  // Write channel registers
  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_idx_q   <= wr_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // One storage word per index; word 0 is the constant ID and never pulses.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
    if (gi == 0) begin : g_id
      assign regs_flat[31:0] = ID_VALUE;
      assign pulse_d[0]      = 1'b0;
    end else begin : g_rw
      logic [31:0] word_q, word_d;
      logic        hit;

      assign hit         = wr_commit && (wr_idx_q == IDX_W'(gi));
      assign pulse_d[gi] = hit;

      // Merge the strobed bytes into this word on a committed write to it
      always_comb begin
        word_d = word_q;
        if (hit) begin
          word_d = merge_bytes(word_q, wdata_q, wstrb_q);
        end
      end

      // Word storage, cleared by reset
      always_ff @(posedge aclk) begin
        if (!aclk_reset_n) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign regs_flat[32*gi +: 32] = word_q;
    end
  end

  // Write pulses appear alongside bvalid, the cycle after the commit edge
  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  // Read lookup from current storage, so a same-edge write is not visible
  always_comb begin
    rd_idx  = aclk_araddr[ADDR_WIDTH-1:2];
    rd_word = OOR_RDATA;
    rd_resp = OOR_RESP;
    if (32'(rd_idx) < NUM_REGS) begin
      rd_resp = RESP_OKAY;
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rd_word = regs_flat[32*i +: 32];
        end
      end
    end
  end

  // Read FSM: capture on AR handshake, hold R until the master takes it
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (aclk_arvalid && arready_q) begin
          rdata_d    = rd_word;
          rresp_d    = rd_resp;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (aclk_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // Read channel registers
  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign aclk_awready = awready_q;
  assign aclk_wready  = wready_q;
  assign aclk_bvalid  = bvalid_q;
  assign aclk_bresp   = bresp_q;
  assign aclk_arready = arready_q;
  assign aclk_rvalid  = rvalid_q;
  assign aclk_rdata   = rdata_q;
  assign aclk_rresp   = rresp_q;
  assign reg_q        = regs_flat;
  assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave: directed scenarios followed by
// randomized AXI-Lite traffic, all checked against a word-array model.
// Honours AXIL_REGFILE_SLVERR_EN for out-of-range expectations.
module tb_axil_regfile_slave;

  localparam int          NREG = 16;
  localparam logic [31:0] ID   = 32'h58475301;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic              aclk;
  logic              aclk_reset_n;
  logic [10:0]       aclk_awaddr;
  logic [2:0]        aclk_awprot;
  logic              aclk_awvalid;
  logic              aclk_awready;
  logic [31:0]       aclk_wdata;
  logic [3:0]        aclk_wstrb;
  logic              aclk_wvalid;
  logic              aclk_wready;
  logic [1:0]        aclk_bresp;
  logic              aclk_bvalid;
  logic              aclk_bready;
  logic [10:0]       aclk_araddr;
  logic [2:0]        aclk_arprot;
  logic              aclk_arvalid;
  logic              aclk_arready;
  logic [31:0]       aclk_rdata;
  logic [1:0]        aclk_rresp;
  logic              aclk_rvalid;
  logic              aclk_rready;
  logic [NREG*32-1:0] reg_q;
  logic [NREG-1:0]   reg_wr_pulse;

  axil_regfile_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(11),
    .NUM_REGS  (NREG),
    .ID_VALUE  (ID)
  ) dut (
    .aclk         (aclk),
    .aclk_reset_n (aclk_reset_n),
    .aclk_awaddr  (aclk_awaddr),
    .aclk_awprot  (aclk_awprot),
    .aclk_awvalid (aclk_awvalid),
    .aclk_awready (aclk_awready),
    .aclk_wdata   (aclk_wdata),
    .aclk_wstrb   (aclk_wstrb),
    .aclk_wvalid  (aclk_wvalid),
    .aclk_wready  (aclk_wready),
    .aclk_bresp   (aclk_bresp),
    .aclk_bvalid  (aclk_bvalid),
    .aclk_bready  (aclk_bready),
    .aclk_araddr  (aclk_araddr),
    .aclk_arprot  (aclk_arprot),
    .aclk_arvalid (aclk_arvalid),
    .aclk_arready (aclk_arready),
    .aclk_rdata   (aclk_rdata),
    .aclk_rresp   (aclk_rresp),
    .aclk_rvalid  (aclk_rvalid),
    .aclk_rready  (aclk_rready),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Total number of pulse-high cycles over all bits, sampled mid-cycle
  int pulse_total = 0;
  always @(negedge aclk) pulse_total <= pulse_total + $countones(reg_wr_pulse);

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents of words 1..NREG-1 (word 0 is the ID)
  logic [31:0] model [NREG];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic compare_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      check_eq($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], (i == 0) ? ID : model[i]);
    end
  endtask

  // Drive one write; b_hold < 0 leaves the response pending on return.
  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output logic [1:0] resp, output logic [15:0] pulse,
                           output int lat, output int viol);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit seen    = 1'b0;
    int t = 0;
    int guard = 0;
    int hs_cyc = 0;
    resp = 2'b11; pulse = '0; lat = -1; viol = 0;
    while (!(aw_done && w_done) && t < 100) begin
      aclk_awvalid = !aw_done && (t >= aw_dly);
      aclk_awaddr  = addr;
      aclk_wvalid  = !w_done && (t >= w_dly);
      aclk_wdata   = data;
      aclk_wstrb   = strb;
      @(negedge aclk);
      if (aclk_awvalid && aclk_awready) begin aw_done = 1'b1; hs_cyc = cyc; end
      if (aclk_wvalid && aclk_wready) begin w_done = 1'b1; hs_cyc = cyc; end
      step();
      t++;
    end
    aclk_awvalid = 1'b0;
    aclk_wvalid  = 1'b0;
    check_eq("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
    if (!(aw_done && w_done)) return;
    aclk_bready = (b_hold == 0);
    while (!seen && guard < 50) begin
      @(negedge aclk);
      if (aclk_bvalid) begin
        seen  = 1'b1;
        lat   = cyc - hs_cyc;
        resp  = aclk_bresp;
        pulse = reg_wr_pulse;
        if (aclk_awready || aclk_wready) viol++;
      end else begin
        step();
        guard++;
      end
    end
    check_eq("bvalid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    for (int h = 0; h < b_hold; h++) begin
      step();
      aclk_awvalid = 1'b1;
      aclk_awaddr  = 11'h00C;
      @(negedge aclk);
      if (!aclk_bvalid || aclk_awready || aclk_wready || aclk_bresp !== resp) viol++;
    end
    aclk_awvalid = 1'b0;
    if (b_hold >= 0) begin
      aclk_bready = 1'b1;
      step();
      if (aclk_bvalid) viol++;
      aclk_bready = 1'b0;
    end else begin
      step();
    end
  endtask

  task automatic axi_read(input logic [10:0] addr, input int ar_dly, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output int viol);
    bit done = 1'b0;
    bit seen = 1'b0;
    int t = 0;
    int guard = 0;
    int hs_cyc = 0;
    data = 'x; resp = 2'b11; lat = -1; viol = 0;
    while (!done && t < 100) begin
      aclk_arvalid = (t >= ar_dly);
      aclk_araddr  = addr;
      @(negedge aclk);
      if (aclk_arvalid && aclk_arready) begin done = 1'b1; hs_cyc = cyc; end
      step();
      t++;
    end
    aclk_arvalid = 1'b0;
    check_eq("ar_accepted", 32'(done), 32'd1);
    if (!done) return;
    aclk_rready = (r_hold == 0);
    while (!seen && guard < 50) begin
      @(negedge aclk);
      if (aclk_rvalid) begin
        seen = 1'b1;
        lat  = cyc - hs_cyc;
        data = aclk_rdata;
        resp = aclk_rresp;
        if (aclk_arready) viol++;
      end else begin
        step();
        guard++;
      end
    end
    check_eq("rvalid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    for (int h = 0; h < r_hold; h++) begin
      step();
      @(negedge aclk);
      if (!aclk_rvalid || aclk_arready || aclk_rdata !== data || aclk_rresp !== resp) viol++;
    end
    aclk_rready = 1'b1;
    step();
    if (aclk_rvalid) viol++;
    aclk_rready = 1'b0;
  endtask

  task automatic write_and_check(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int aw_dly, input int w_dly, input int b_hold);
    int          idx;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
    logic [1:0]  resp;
    logic [15:0] pulse;
    int          lat, viol, p0;
    idx       = int'(addr) / 4;
    exp_resp  = (idx >= NREG && SLVERR_EN) ? 2'b10 : 2'b00;
    exp_pulse = '0;
    if (idx > 0 && idx < NREG) exp_pulse[idx] = 1'b1;
    p0 = pulse_total;
    axi_write(addr, data, strb, aw_dly, w_dly, b_hold, resp, pulse, lat, viol);
    step();
    $display("wr addr=%03h data=%08h strb=%h aw_dly=%0d w_dly=%0d b_hold=%0d bresp=%0d lat=%0d",
             addr, data, strb, aw_dly, w_dly, b_hold, resp, lat);
    check_eq("bresp", 32'(resp), 32'(exp_resp));
    check_eq("b_latency", 32'(lat), 32'd2);
    check_eq("pulse_at_b", 32'(pulse), 32'(exp_pulse));
    check_eq("pulse_cycles", 32'(pulse_total - p0), 32'($countones(exp_pulse)));
    check_eq("b_hold_viol", 32'(viol), 32'd0);
    if (idx > 0 && idx < NREG) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
    compare_regs("wr");
  endtask

  task automatic read_and_check(input logic [10:0] addr, input int ar_dly, input int r_hold);
    int          idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat, viol;
    idx = int'(addr) / 4;
    if (idx == 0) begin
      exp_data = ID; exp_resp = 2'b00;
    end else if (idx < NREG) begin
      exp_data = model[idx]; exp_resp = 2'b00;
    end else if (SLVERR_EN) begin
      exp_data = 32'h0; exp_resp = 2'b10;
    end else begin
      exp_data = 32'hDEADBEEF; exp_resp = 2'b00;
    end
    axi_read(addr, ar_dly, r_hold, data, resp, lat, viol);
    $display("rd addr=%03h ar_dly=%0d r_hold=%0d rdata=%08h rresp=%0d lat=%0d",
             addr, ar_dly, r_hold, data, resp, lat);
    check_eq("rdata", data, exp_data);
    check_eq("rresp", 32'(resp), 32'(exp_resp));
    check_eq("r_latency", 32'(lat), 32'd1);
    check_eq("r_hold_viol", 32'(viol), 32'd0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse;
    int          lat, viol;

    aclk_reset_n = 1'b0;
    aclk_awaddr = '0; aclk_awprot = '0; aclk_awvalid = 1'b0;
    aclk_wdata = '0; aclk_wstrb = '0; aclk_wvalid = 1'b0; aclk_bready = 1'b0;
    aclk_araddr = '0; aclk_arprot = '0; aclk_arvalid = 1'b0; aclk_rready = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    repeat (3) step();
    @(negedge aclk);
    check_eq("rst_awready", 32'(aclk_awready), 32'd0);
    check_eq("rst_wready",  32'(aclk_wready),  32'd0);
    check_eq("rst_bvalid",  32'(aclk_bvalid),  32'd0);
    check_eq("rst_bresp",   32'(aclk_bresp),   32'd0);
    check_eq("rst_arready", 32'(aclk_arready), 32'd0);
    check_eq("rst_rvalid",  32'(aclk_rvalid),  32'd0);
    check_eq("rst_rdata",   aclk_rdata,        32'd0);
    check_eq("rst_rresp",   32'(aclk_rresp),   32'd0);
    check_eq("rst_pulse",   32'(reg_wr_pulse), 32'd0);
    compare_regs("rst");
    aclk_reset_n = 1'b1;
    step(); step();

    // Basic write / read-back, AW and W together
    write_and_check(11'h004, 32'hA5A5_1234, 4'hF, 0, 0, 0);
    read_and_check(11'h004, 0, 0);
    // W leads AW by three cycles, partial strobes
    write_and_check(11'h008, 32'h1122_3344, 4'b0101, 3, 0, 0);
    read_and_check(11'h008, 0, 0);
    // ID register is read-only
    read_and_check(11'h000, 0, 0);
    write_and_check(11'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    read_and_check(11'h000, 0, 0);
    // Out-of-range accesses
    read_and_check(11'h7FC, 0, 0);
    write_and_check(11'h7FC, 32'h1357_9BDF, 4'hF, 0, 1, 0);
    // Back-pressure on B and R
    write_and_check(11'h014, 32'hFEED_BEEF, 4'hF, 1, 0, 10);
    read_and_check(11'h004, 0, 10);

    // Read on the same edge as the write commit sees the old value
    write_and_check(11'h018, 32'h1234_5678, 4'hF, 0, 0, 0);
    step(); step();
    fork
      write_and_check(11'h018, 32'h5555_AAAA, 4'hF, 0, 0, 0);
      read_and_check(11'h018, 1, 0);
    join
    read_and_check(11'h018, 0, 0);

    // Reset while a write response is pending
    axi_write(11'h010, 32'hCAFE_F00D, 4'hF, 0, 0, -1, resp, pulse, lat, viol);
    check_eq("rst_mid_bvalid_pending", 32'(aclk_bvalid), 32'd1);
    aclk_reset_n = 1'b0;
    step();
    check_eq("rst_mid_bvalid_dropped", 32'(aclk_bvalid), 32'd0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    compare_regs("rst_mid");
    aclk_reset_n = 1'b1;
    step();
    write_and_check(11'h010, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    read_and_check(11'h010, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int          idx;
      logic [10:0] a;
      if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(NREG, 511));
      else                           idx = int'($urandom_range(0, NREG - 1));
      a = {9'(idx), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        write_and_check(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end else begin
        read_and_check(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
AXI4-Lite responder, the slave end of the host AXI-Lite master path (32-bit data, 11-bit address). It implements a word-addressed register file.
- Word 0 is a read-only ID register; the remaining words are read/write control registers.
- Register contents and per-register write pulses drive user logic.
- It sits between the system_top AXI-Lite interconnect port and local control logic.

Parameters:
DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
ADDR_WIDTH, 11, AXI-Lite byte-address width.
NUM_REGS, 16, number of 32-bit words; legal range 2..2**(ADDR_WIDTH-2).
ID_VALUE, 32'h58475301, constant returned by word 0.

Ports:
aclk  in  1  clock
aclk_reset_n  in  1  synchronous active-low reset
aclk_awaddr  in  ADDR_WIDTH  write address
aclk_awprot  in  3  ignored
aclk_awvalid  in  1  write address valid
aclk_awready  out  1  write address ready
aclk_wdata  in  32  write data
aclk_wstrb  in  4  byte strobes
aclk_wvalid  in  1  write data valid
aclk_wready  out  1  write data ready
aclk_bresp  out  2  write response
aclk_bvalid  out  1  write response valid
aclk_bready  in  1  write response ready
aclk_araddr  in  ADDR_WIDTH  read address
aclk_arprot  in  3  ignored
aclk_arvalid  in  1  read address valid
aclk_arready  out  1  read address ready
aclk_rdata  out  32  read data
aclk_rresp  out  2  read response
aclk_rvalid  out  1  read data valid
aclk_rready  in  1  read data ready
reg_q  out  NUM_REGS*32  flattened register contents; word i at [32*i+31:32*i]; word 0 = ID_VALUE
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after a committed write to word i; bit 0 always 0

Behaviour:
- One clock (aclk). Reset is synchronous and active-low (aclk_reset_n).
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0, reg_pulse=0. All RW registers are 0.
- A reset asserted mid-transaction drops all pending AW/W/AR/B/R state without issuing a response.
- Addressing:
  - word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - An index >= NUM_REGS is out of range.
- Write channel, FSM W_IDLE / W_RESP:
  - W_IDLE: awready = !aw_held, wready = !w_held. AW and W are accepted independently, in either order or in the same cycle, and latched.
  - When both are held, the write commits on the next edge:
    - each byte with wstrb[b]=1 is updated;
    - writes to word 0 or to an out-of-range index are discarded;
    - held flags clear; bvalid=1, bresp as defined below; FSM -> W_RESP.
  - W_RESP: awready=wready=0; bvalid held until bready=1, then -> W_IDLE.
  - Latency: awvalid&wvalid in cycle N with ready=1 -> bvalid in cycle N+2.
  - At most one write is outstanding.
- Read channel, FSM R_IDLE / R_DATA:
  - R_IDLE: arready=1. On arvalid handshake, rdata is captured on the next edge from the current register value; rvalid=1; FSM -> R_DATA.
  - R_DATA: arready=0; rdata/rresp stable until rready=1, then -> R_IDLE.
  - Latency: AR handshake in cycle N -> rvalid in cycle N+1.
- Simultaneous read and write commit to the same word on the same edge: the read returns the pre-write value.
- The read and write channels are fully independent; no ordering between them.
- Write to word 0: data discarded, bresp=OKAY, no pulse.
- Out-of-range responses depend on the optional feature below.

Optional Feature:
Macro AXIL_REGFILE_SLVERR_EN.
- Defined: out-of-range read returns rdata=0, rresp=2'b10 (SLVERR). Out-of-range write returns bresp=2'b10 and has no effect.
- Undefined: out-of-range read returns rdata=32'hDEADBEEF, rresp=OKAY. Out-of-range write returns bresp=OKAY and has no effect.
- In both cases in-range accesses return OKAY.

Decomposition:
- Package axil_regfile_pkg holds:
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - typedef enum wr_state_t {W_IDLE, W_RESP};
  - typedef enum rd_state_t {R_IDLE, R_DATA};
  - constant DEFAULT_RDATA=32'hDEADBEEF.
- No sub-module; the read and write FSMs are two always blocks in one module.

Test Plan:
- Reset, then write 32'hA5A5_1234 with wstrb=4'hF to 0x004 (AW and W in the same cycle) -> bvalid at N+2, bresp=0, reg_wr_pulse[1] for one cycle. Read 0x004 -> rdata=32'hA5A5_1234.
- Write W to 0x008 three cycles before AW, wstrb=4'b0101, data 32'h11223344 over 0 -> register = 32'h00220044.
- Read 0x000 -> ID_VALUE. Write 0xFFFFFFFF to 0x000 -> bresp=0, a following read still returns ID_VALUE, no pulse.
- Read 0x7FC (index 511 >= 16):
  - with AXIL_REGFILE_SLVERR_EN -> rresp=2, rdata=0;
  - without it -> rresp=0, rdata=32'hDEADBEEF.
- Hold bready=0 for 10 cycles -> bvalid stays 1, awready=wready=0, and a new AW is not accepted. Same check for rvalid with rready=0.
- Reset asserted during W_RESP with bvalid=1 -> next cycle bvalid=0, registers are 0, and a subsequent write completes normally.
